// File: rtl/instr_enc.sv
// instr_enc: turns one MSP430 instruction request into its 1-3 word
// memory image (instruction word, src extension, dst extension) and
// writes the words to program memory at an auto-incrementing address.
//
// state | meaning
// IDLE  | ready for a request or an address load
// INSTR | presenting the instruction word
// SRC   | presenting the source extension word
// DST   | presenting the destination extension word
module instr_enc #(
    parameter logic [15:0] BASE_ADDR = 16'hC000,
    parameter logic [15:0] ADDR_STEP = 16'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_fmt,
    input  logic [8:0]  req_op,
    input  logic [3:0]  req_SA,
    input  logic [3:0]  req_DA,
    input  logic [1:0]  req_As,
    input  logic        req_Ad,
    input  logic        req_BW,
    input  logic [9:0]  req_off,
    input  logic [15:0] req_sext,
    input  logic [15:0] req_dext,
    input  logic        ld_addr,
    input  logic [15:0] ld_val,
    output logic [15:0] MDB_in,
    output logic [15:0] wr_addr,
    output logic        MW,
    input  logic        MW_ready,
    output logic        w_last,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INSTR = 2'd1,
        SRC   = 2'd2,
        DST   = 2'd3
    } state_t;

    localparam logic [1:0] FMT_I  = 2'd1;
    localparam logic [1:0] FMT_II = 2'd2;
    localparam logic [1:0] FMT_J  = 2'd3;

    state_t      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic [15:0] mdb_q, mdb_d;
    logic [15:0] addr_q, addr_d;
    logic        mw_q, mw_d;
    logic        last_q, last_d;
    logic        err_q, err_d;
    logic [15:0] sext_q, sext_d;
    logic [15:0] dext_q, dext_d;
    logic        need_src_q, need_src_d;
    logic        need_dst_q, need_dst_d;

    logic        illegal;
    logic        grp_bad;
    logic        no_imm_op;
    logic [3:0]  src_reg;
    logic        req_need_src;
    logic        req_need_dst;
    logic [15:0] instr_word;

    // Decode the incoming request: legality, extension needs, first word.
    always_comb begin
        // Single-operand ops live in the 000100xxx group of INSTR[15:7];
        // RETI, SWPB and SXT have no meaningful immediate/autoinc source.
        grp_bad      = (req_op[8:3] != 6'b000100);
        no_imm_op    = (req_op[2:0] == 3'b001) || (req_op[2:0] == 3'b011) ||
                       (req_op[2:0] == 3'b110);
        illegal      = (req_fmt == 2'd0) ||
                       ((req_fmt == FMT_II) && (grp_bad || ((req_As == 2'b11) && no_imm_op)));
        // Single-operand instructions carry their operand in the DA field.
        src_reg      = (req_fmt == FMT_I) ? req_SA : req_DA;
        // R3 as an indexed source is the constant generator, and @R0+ is an
        // immediate; only those two cases pull a source extension word.
        req_need_src = (req_fmt != FMT_J) &&
                       (((req_As == 2'b01) && (src_reg != 4'd3)) ||
                        ((req_As == 2'b11) && (src_reg == 4'd0)));
        req_need_dst = (req_fmt == FMT_I) && req_Ad;
        case (req_fmt)
            FMT_I:   instr_word = {req_op[3:0], req_SA, req_Ad, req_BW, req_As, req_DA};
            FMT_II:  instr_word = {req_op[8:0], req_BW, req_As, req_DA};
            FMT_J:   instr_word = {3'b001, req_op[2:0], req_off};
            default: instr_word = 16'h0000;
        endcase
    end

    // Next-state and output computation for the emit sequence.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        mdb_d       = mdb_q;
        addr_d      = addr_q;
        mw_d        = mw_q;
        last_d      = last_q;
        err_d       = 1'b0;
        sext_d      = sext_q;
        dext_d      = dext_q;
        need_src_d  = need_src_q;
        need_dst_d  = need_dst_q;

        if (state_q == IDLE) begin
            // The load lands before the request, so its first word uses ld_val.
            if (ld_addr) begin
                addr_d = {ld_val[15:1], 1'b0};
            end
            if (req_valid) begin
                if (illegal) begin
                    err_d = 1'b1;
                end else begin
                    state_d     = INSTR;
                    req_ready_d = 1'b0;
                    mw_d        = 1'b1;
                    mdb_d       = instr_word;
                    last_d      = !req_need_src && !req_need_dst;
                    sext_d      = req_sext;
                    dext_d      = req_dext;
                    need_src_d  = req_need_src;
                    need_dst_d  = req_need_dst;
                end
            end
        end else if (mw_q && MW_ready) begin
            addr_d = addr_q + ADDR_STEP;
            if ((state_q == INSTR) && need_src_q) begin
                state_d = SRC;
                mdb_d   = sext_q;
                last_d  = !need_dst_q;
            end else if ((state_q != DST) && need_dst_q) begin
                state_d = DST;
                mdb_d   = dext_q;
                last_d  = 1'b1;
            end else begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                mw_d        = 1'b0;
                last_d      = 1'b0;
            end
        end
    end

    // State and registered outputs; reset discards any words still pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            mdb_q       <= 16'h0000;
            addr_q      <= BASE_ADDR;
            mw_q        <= 1'b0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            sext_q      <= 16'h0000;
            dext_q      <= 16'h0000;
            need_src_q  <= 1'b0;
            need_dst_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            mdb_q       <= mdb_d;
            addr_q      <= addr_d;
            mw_q        <= mw_d;
            last_q      <= last_d;
            err_q       <= err_d;
            sext_q      <= sext_d;
            dext_q      <= dext_d;
            need_src_q  <= need_src_d;
            need_dst_q  <= need_dst_d;
        end
    end

    assign req_ready = req_ready_q;
    assign MDB_in    = mdb_q;
    assign wr_addr   = addr_q;
    assign MW        = mw_q;
    assign w_last    = last_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_enc.sv
// Bench for instr_enc: directed requests push expected words into a
// scoreboard; a negedge monitor pops and compares every accepted word.
module tb_instr_enc;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_fmt;
    logic [8:0]  req_op;
    logic [3:0]  req_SA;
    logic [3:0]  req_DA;
    logic [1:0]  req_As;
    logic        req_Ad;
    logic        req_BW;
    logic [9:0]  req_off;
    logic [15:0] req_sext;
    logic [15:0] req_dext;
    logic        ld_addr;
    logic [15:0] ld_val;
    logic [15:0] MDB_in;
    logic [15:0] wr_addr;
    logic        MW;
    logic        MW_ready;
    logic        w_last;
    logic        err;

    instr_enc dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_fmt(req_fmt), .req_op(req_op), .req_SA(req_SA), .req_DA(req_DA),
        .req_As(req_As), .req_Ad(req_Ad), .req_BW(req_BW), .req_off(req_off),
        .req_sext(req_sext), .req_dext(req_dext),
        .ld_addr(ld_addr), .ld_val(ld_val),
        .MDB_in(MDB_in), .wr_addr(wr_addr), .MW(MW), .MW_ready(MW_ready),
        .w_last(w_last), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
        logic        l;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_addr;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic push(input logic [15:0] d, input logic l);
        exp_t e;
        e.a = exp_addr;
        e.d = d;
        e.l = l;
        sb.push_back(e);
        exp_addr = exp_addr + 16'd2;
    endtask

    // Monitor: compare each accepted word; also check held words stay stable.
    always @(negedge clk) begin
        if (!rst && MW) begin
            if (sb.size() == 0) begin
                if (MW_ready) chk("unexpected_word", MDB_in, 16'hxxxx);
            end else if (MW_ready) begin
                exp_t e;
                e = sb.pop_front();
                chk("word_data", MDB_in, e.d);
                chk("word_addr", wr_addr, e.a);
                chk("word_last", {15'd0, w_last}, {15'd0, e.l});
            end else begin
                chk("stall_data", MDB_in, sb[0].d);
                chk("stall_addr", wr_addr, sb[0].a);
            end
        end
    end

    // Drive a request for one accepting edge; returns #1 after that edge.
    task automatic issue(input logic [1:0] fmt, input logic [8:0] op, input logic [3:0] sa,
                         input logic [3:0] da, input logic [1:0] as_, input logic ad,
                         input logic [9:0] off, input logic [15:0] sx, input logic [15:0] dx,
                         input logic ld, input logic [15:0] ldv);
        @(negedge clk);
        req_fmt = fmt; req_op = op; req_SA = sa; req_DA = da; req_As = as_;
        req_Ad = ad; req_BW = 1'b0; req_off = off; req_sext = sx; req_dext = dx;
        ld_addr = ld; ld_val = ldv; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        ld_addr   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(req_ready && sb.size() == 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got pending=%0d expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_fmt = 2'd0; req_op = 9'd0; req_SA = 4'd0;
        req_DA = 4'd0; req_As = 2'd0; req_Ad = 1'b0; req_BW = 1'b0; req_off = 10'd0;
        req_sext = 16'd0; req_dext = 16'd0; ld_addr = 1'b0; ld_val = 16'd0; MW_ready = 1'b1;
        exp_addr = 16'hC000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {15'd0, req_ready}, 16'd1);
        chk("rst_mw", {15'd0, MW}, 16'd0);
        chk("rst_w_last", {15'd0, w_last}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        chk("rst_mdb", MDB_in, 16'h0000);
        chk("rst_addr", wr_addr, 16'hC000);

        // MOV R5,R6
        push(16'h4506, 1'b1);
        issue(2'd1, 9'd4, 4'd5, 4'd6, 2'd0, 1'b0, 10'd0, 16'd0, 16'd0, 1'b0, 16'd0);
        wait_done("mov_rr");

        // MOV #1234h,&0200h
        push(16'h40B2, 1'b0); push(16'h1234, 1'b0); push(16'h0200, 1'b1);
        issue(2'd1, 9'd4, 4'd0, 4'd2, 2'd3, 1'b1, 10'd0, 16'h1234, 16'h0200, 1'b0, 16'd0);
        wait_done("mov_imm_abs");

        // MOV #1,R4 through the constant generator
        push(16'h4314, 1'b1);
        issue(2'd1, 9'd4, 4'd3, 4'd4, 2'd1, 1'b0, 10'd0, 16'hDEAD, 16'hBEEF, 1'b0, 16'd0);
        wait_done("mov_cg");

        // JMP -1 with memory stalled for 3 cycles
        @(posedge clk); #1 MW_ready = 1'b0;
        push(16'h3FFF, 1'b1);
        issue(2'd3, 9'd7, 4'd0, 4'd0, 2'd0, 1'b0, 10'h3FF, 16'd0, 16'd0, 1'b0, 16'd0);
        repeat (3) @(posedge clk);
        #1 MW_ready = 1'b1;
        wait_done("jmp_stall");

        // Address wrap: load FFFE, MOV #5,R7
        exp_addr = 16'hFFFE;
        push(16'h4037, 1'b0); push(16'h0005, 1'b1);
        issue(2'd1, 9'd4, 4'd0, 4'd7, 2'd3, 1'b0, 10'd0, 16'h0005, 16'd0, 1'b1, 16'hFFFE);
        wait_done("wrap");
        chk("wrap_addr_after", wr_addr, 16'h0002);

        // PUSH R5, PUSH 4(R5), MOV R5,2(R6)
        push(16'h1205, 1'b1);
        issue(2'd2, 9'b000100100, 4'd0, 4'd5, 2'd0, 1'b0, 10'd0, 16'd0, 16'd0, 1'b0, 16'd0);
        wait_done("push_reg");
        push(16'h1215, 1'b0); push(16'h0004, 1'b1);
        issue(2'd2, 9'b000100100, 4'd0, 4'd5, 2'd1, 1'b0, 10'd0, 16'h0004, 16'd0, 1'b0, 16'd0);
        wait_done("push_idx");
        push(16'h4586, 1'b0); push(16'h0002, 1'b1);
        issue(2'd1, 9'd4, 4'd5, 4'd6, 2'd0, 1'b1, 10'd0, 16'd0, 16'h0002, 1'b0, 16'd0);
        wait_done("mov_dst_idx");

        // Odd load value is forced even; JNE +5
        exp_addr = 16'h2000;
        push(16'h2005, 1'b1);
        issue(2'd3, 9'd0, 4'd0, 4'd0, 2'd0, 1'b0, 10'd5, 16'd0, 16'd0, 1'b1, 16'h2001);
        wait_done("jne_ld_odd");

        // Illegal requests: fmt 0, SXT @R5+, bad FMT_II group
        issue(2'd0, 9'd4, 4'd5, 4'd6, 2'd0, 1'b0, 10'd0, 16'd0, 16'd0, 1'b0, 16'd0);
        chk("err_fmt0_pulse", {15'd0, err}, 16'd1);
        chk("err_fmt0_mw", {15'd0, MW}, 16'd0);
        @(posedge clk); #1;
        chk("err_fmt0_drop", {15'd0, err}, 16'd0);
        chk("err_fmt0_ready", {15'd0, req_ready}, 16'd1);
        issue(2'd2, 9'b000100011, 4'd0, 4'd5, 2'd3, 1'b0, 10'd0, 16'd0, 16'd0, 1'b0, 16'd0);
        chk("err_sxt_pulse", {15'd0, err}, 16'd1);
        chk("err_sxt_mw", {15'd0, MW}, 16'd0);
        issue(2'd2, 9'b000101000, 4'd0, 4'd5, 2'd0, 1'b0, 10'd0, 16'd0, 16'd0, 1'b0, 16'd0);
        chk("err_grp_pulse", {15'd0, err}, 16'd1);
        @(posedge clk); #1;
        chk("err_addr_kept", wr_addr, exp_addr);
        chk("err_no_word", {15'd0, MW}, 16'd0);

        // Reset while the source extension word is being held
        @(posedge clk); #1 MW_ready = 1'b0;
        push(16'h40B2, 1'b0);
        issue(2'd1, 9'd4, 4'd0, 4'd2, 2'd3, 1'b1, 10'd0, 16'h1234, 16'h0200, 1'b0, 16'd0);
        MW_ready = 1'b1;
        @(posedge clk); #1 MW_ready = 1'b0;
        chk("src_word", MDB_in, 16'h1234);
        chk("src_mw", {15'd0, MW}, 16'd1);
        chk("src_last", {15'd0, w_last}, 16'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_mw", {15'd0, MW}, 16'd0);
        chk("midrst_addr", wr_addr, 16'hC000);
        chk("midrst_ready", {15'd0, req_ready}, 16'd1);
        rst = 1'b0; MW_ready = 1'b1;
        exp_addr = 16'hC000;

        // Normal operation resumes from the base address
        push(16'h4506, 1'b1);
        issue(2'd1, 9'd4, 4'd5, 4'd6, 2'd0, 1'b0, 10'd0, 16'd0, 16'd0, 1'b0, 16'd0);
        wait_done("after_rst");

        chk("sb_empty", sb.size(), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
